seq_divider: RTL

Multi-cycle unsigned restoring divider with a start/done handshake. It sequences a compare-subtract-shift datapath: a working remainder register, a quotient shift register, a subtracter and a magnitude comparison, paced by a down-counter. It lets one subtracter serve a WIDTH-bit division instead of an unrolled array, and sits beside the arithmetic units as a shared, controller-driven function block.

---
 rtl/seq_divider.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Multi-cycle unsigned restoring divider. One subtracter and one magnitude
// compare are reused across WIDTH steps. A down-counter paces the steps.
//
// Optional feature macro: DIV_ZERO_DETECT_EN
//   When defined, a zero divisor skips the step sequence and completes in a
//   single cycle. The div_by_zero flag records that it happened.
//
// Handshake: start is sampled only in IDLE or DONE. The edge that samples
// start=1 captures the operands. busy is high while steps run. done is a
// one-cycle pulse, and quotient/remainder are valid in that cycle. The
// results then hold until the next completion. start during CALC is dropped.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   start       in   division request
//   dividend    in   WIDTH-bit unsigned dividend
//   divisor     in   WIDTH-bit unsigned divisor
//   busy        out  high while in CALC
//   done        out  high for the one cycle spent in DONE
//   quotient    out  last completed quotient
//   remainder   out  last completed remainder
//   div_by_zero out  last completion was a zero divide (macro only)
//   dbg_state   out  FSM state: 0=IDLE, 1=CALC, 2=DONE
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
`ifdef DIV_ZERO_DETECT_EN
    output logic             div_by_zero,
`endif
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH:0]   r_rem;       // working remainder R, one bit wider than D
    logic [WIDTH-1:0] r_quo;       // quotient shift register Q
    logic [WIDTH-1:0] r_div;       // captured divisor D
    logic [CW-1:0]    r_cnt;       // steps remaining after the current one
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
`ifdef DIV_ZERO_DETECT_EN
    logic             r_dbz;
`endif

    // One restoring step: shift {R,Q} left as one vector. Then trial-subtract D
    // from the new R. The extra R bit keeps the shifted value exact before
    // the compare.
    logic [2*WIDTH:0] w_shift;
    logic [WIDTH:0]   w_shift_r;
    logic [WIDTH-1:0] w_shift_q;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH:0]   w_next_r;
    logic [WIDTH-1:0] w_next_q;
    logic             w_last;

    assign w_shift   = {r_rem, r_quo} << 1;
    assign w_shift_r = w_shift[2*WIDTH:WIDTH];
    assign w_shift_q = w_shift[WIDTH-1:0];
    assign w_ge      = (w_shift_r >= {1'b0, r_div});
    assign w_diff    = w_shift_r - {1'b0, r_div};
    assign w_next_r  = w_ge ? w_diff : w_shift_r;
    // The shift leaves Q[0] at zero. OR in the quotient bit for this step.
    assign w_next_q  = w_shift_q | {{(WIDTH-1){1'b0}}, w_ge};
    assign w_last    = (r_cnt == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
            r_dbz       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_div <= divisor;
                        r_rem <= '0;
                        r_quo <= dividend;
                        r_cnt <= CW'(WIDTH - 1);
`ifdef DIV_ZERO_DETECT_EN
                        if (divisor == '0) begin
                            // Short-circuit. The values match what the full
                            // step sequence would produce for D=0.
                            r_state     <= ST_DONE;
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_state <= ST_CALC;
                        end
`else
                        r_state <= ST_CALC;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    r_rem <= w_next_r;
                    r_quo <= w_next_q;
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        r_quotient  <= w_next_q;
                        r_remainder <= w_next_r[WIDTH-1:0];
`ifdef DIV_ZERO_DETECT_EN
                        r_dbz       <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (r_state == ST_CALC);
    assign done      = (r_state == ST_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign dbg_state = r_state;
`ifdef DIV_ZERO_DETECT_EN
    assign div_by_zero = r_dbz;
`endif

endmodule
